uart_mem_loader: RTL and testbench
==================================

# uart_mem_loader

Boot-time program loader that receives an 8N1 serial byte stream and writes it sequentially into the 512x8 program/data memory starting at address 0. It sits directly upstream of mem_512x8b and drives its address, write-enable and write-data ports while the core is held in reset. On completion it asserts o_done, which releases the core. An optional echo path reads each byte back from memory and retransmits it for host-side verification.

## Interface
- pBAUD_DIV, 104: i_clk cycles per serial bit (12 MHz / 115200); must be ≥ 8.
- i_clk  in  1  system clock.
- i_nrst  in  1  asynchronous, active-low reset.
- i_rx  in  1  serial input, idle high, asynchronous to i_clk.
- o_addr  out  9  memory address, to mem i_addr.
- o_we  out  1  one-cycle write strobe, to mem i_we.
- o_wdata  out  8  write data, to mem i_wdata.
- o_re  out  1  one-cycle read strobe, to mem i_re (echo only, else 0).
- i_rdata  in  8  memory read data (echo only).
- o_tx  out  1  serial echo output, idle high.
- o_busy  out  1  load in progress.
- o_done  out  1  load complete; sticky until reset.
- o_err  out  1  framing error seen; sticky until reset.

## Operation
- Frame: LEN_LO byte, LEN_HI byte (bit0 = len[8], bits 7:1 ignored), then N data bytes. N = {len[8],len[7:0]}; N = 0 means 512.
- RX: two-flop synchroniser on i_rx; start detected on falling edge, re-checked at mid-bit (pBAUD_DIV/2); false start returns to idle. Data bits sampled at bit centres, LSB first. Stop bit low → byte discarded, o_err set, FSM state unchanged.
- FSM: IDLE → (first valid byte) LEN_HI → DATA → DONE. With echo: DATA → ECHO_RD → ECHO_TX → DATA/DONE.
- DATA: each valid byte → o_wdata = byte, o_addr = count, o_we = 1 for one cycle; count increments (9-bit + terminal flag, no wrap). After byte N, → DONE.
- DONE: o_done = 1, o_busy = 0; further RX bytes ignored. Only reset restarts loading.
- o_busy = 1 from first LEN_LO byte accepted until DONE.
- Reset mid-load: all state cleared; memory contents already written are not cleared.
- o_we and o_re never asserted in the same cycle.

## Timing
- Reset values: o_addr 0, o_we 0, o_wdata 0, o_re 0, o_tx 1, o_busy 0, o_done 0, o_err 0.
- o_we pulses exactly one cycle, the cycle after the stop-bit centre sample; o_addr/o_wdata stable during and one cycle after the pulse (the memory registers write data one cycle late).
- Echo readback: o_re asserted 2 cycles after o_we (write committed); i_rdata sampled exactly 1 cycle after o_re (memory returns 0 when not reading).
- o_done rises 1 cycle after the final o_we (no echo) or after the final echo stop bit completes (echo).
- Byte-to-byte minimum spacing is 10 bit times; echo TX (10 bit times) overlaps RX of the next byte, so no bytes are lost at line rate.

## Configuration
- LOADER_ECHO_EN defined: ECHO_RD/ECHO_TX states, TX shifter and readback compiled in; each stored byte read back and sent on o_tx (8N1, pBAUD_DIV).
- Undefined: o_re tied 0, o_tx tied 1, i_rdata unused; DATA → DONE directly.

## Structure
- Shared package/header loader_pkg: FSM state encodings, MEM_DEPTH = 512, ADDR_W = 9, frame constants.
- One sub-module: loader_uart_rx (synchroniser, bit timer, shifter, o_valid/o_byte/o_ferr). TX shifter stays inline.

## Test plan
- Bytes 0x03,0x00,0xA5,0x5A,0xFF → o_we at addr 0,1,2 with data A5,5A,FF; o_done 1 cycle after third o_we; o_busy low.
- Length 0x00,0x00 then 512 bytes (i & 0xFF) → 512 writes, last addr 0x1FF data 0xFF, o_done; extra byte 0x11 afterwards → no o_we.
- Byte with stop bit low mid-DATA → o_err = 1, no write, next valid byte written to the same address.
- 0.25-bit low glitch on i_rx in IDLE → no byte accepted, o_busy stays 0.
- Assert i_nrst after 2 of 5 data bytes → all outputs at reset values; fresh frame loads from addr 0.
- LOADER_ECHO_EN, frame 0x02,0x00,0x3C,0xC3 → o_re 2 cycles after each o_we at same addr; o_tx emits 0x3C then 0xC3; o_done after final stop bit.

Source files
------------

// File: rtl/loader_pkg.sv
// rtl/loader_pkg.sv - shared constants and state encodings for the UART memory loader
package loader_pkg;

  localparam int MEM_DEPTH  = 512;
  localparam int ADDR_W     = 9;
  localparam int DATA_W     = 8;
  localparam int FRAME_BITS = 10;

  // Loader sequencer states; the echo states are only reachable with LOADER_ECHO_EN
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_LEN_HI  = 3'd1,
    ST_DATA    = 3'd2,
    ST_ECHO_RD = 3'd3,
    ST_ECHO_TX = 3'd4,
    ST_DONE    = 3'd5
  } ld_state_e;

  // Serial receiver states
  typedef enum logic [1:0] {
    RX_IDLE  = 2'd0,
    RX_START = 2'd1,
    RX_DATA  = 2'd2,
    RX_STOP  = 2'd3
  } rx_state_e;

endpackage

// File: rtl/loader_uart_rx.sv
// rtl/loader_uart_rx.sv - 8N1 receiver: synchroniser, bit timer, shifter, framing check
module loader_uart_rx
  import loader_pkg::*;
#(
  parameter int pBAUD_DIV = 104
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_rx,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_byte,
  output logic              o_ferr
);

  localparam int CW = $clog2(pBAUD_DIV);
  localparam logic [CW-1:0] HALF_M1 = CW'(pBAUD_DIV / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(pBAUD_DIV - 1);

  logic              sync1_q, sync2_q, prev_q;
  rx_state_e         state_q;
  logic [CW-1:0]     cnt_q;
  logic [2:0]        bit_q;
  logic [DATA_W-1:0] shift_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= i_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Frame receiver: mid-bit start re-check, centre sampling LSB first, stop-bit validation
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q <= RX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      o_valid <= 1'b0;
      o_byte  <= '0;
      o_ferr  <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      o_ferr  <= 1'b0;
      case (state_q)
        RX_IDLE: begin
          cnt_q <= '0;
          if (prev_q && !sync2_q) state_q <= RX_START;
        end
        RX_START: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            bit_q   <= '0;
            state_q <= sync2_q ? RX_IDLE : RX_DATA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_DATA: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {sync2_q, shift_q[DATA_W-1:1]};
            bit_q   <= bit_q + 3'd1;
            if (bit_q == 3'(DATA_W - 1)) state_q <= RX_STOP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RX_STOP: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            state_q <= RX_IDLE;
            if (sync2_q) begin
              o_valid <= 1'b1;
              o_byte  <= shift_q;
            end else begin
              o_ferr <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= RX_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/uart_mem_loader.sv
// rtl/uart_mem_loader.sv - serial boot loader writing a length-prefixed stream into memory; LOADER_ECHO_EN adds readback echo
module uart_mem_loader
  import loader_pkg::*;
#(
  parameter int pBAUD_DIV = 104
) (
  input  logic              i_clk,
  input  logic              i_nrst,
  input  logic              i_rx,
  output logic [ADDR_W-1:0] o_addr,
  output logic              o_we,
  output logic [DATA_W-1:0] o_wdata,
  output logic              o_re,
  input  logic [DATA_W-1:0] i_rdata,
  output logic              o_tx,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  logic              rx_valid, rx_ferr;
  logic [DATA_W-1:0] rx_byte;

  loader_uart_rx #(.pBAUD_DIV(pBAUD_DIV)) u_rx (
    .i_clk  (i_clk),
    .i_nrst (i_nrst),
    .i_rx   (i_rx),
    .o_valid(rx_valid),
    .o_byte (rx_byte),
    .o_ferr (rx_ferr)
  );

  ld_state_e         state_q;
  logic [ADDR_W-1:0] len_q, count_q, addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic              we_q, busy_q, done_q, err_q;
  logic              byte_avail, is_last;
  logic [DATA_W-1:0] byte_in;

  // Length 0 encodes 512: len-1 wraps to 511, so the compare needs no special case
  assign is_last = (count_q == len_q - ADDR_W'(1));

`ifdef LOADER_ECHO_EN
  localparam int CW = $clog2(pBAUD_DIV);
  localparam logic [CW-1:0] BAUD_M1 = CW'(pBAUD_DIV - 1);

  logic              pend_q, last_q, re_q, tx_q, tx_busy_q, tx_sent_q;
  logic [DATA_W-1:0] pend_byte_q, echo_byte_q;
  logic [DATA_W:0]   tx_sh_q;
  logic [3:0]        tx_bits_q;
  logic [1:0]        wait_q;
  logic [CW-1:0]     tx_baud_q;

  // A byte that lands while the echo is busy is parked and consumed first on return to DATA
  assign byte_avail = rx_valid | pend_q;
  assign byte_in    = pend_q ? pend_byte_q : rx_byte;
  assign o_re       = re_q;
  assign o_tx       = tx_q;
`else
  logic unused_rdata;

  assign byte_avail   = rx_valid;
  assign byte_in      = rx_byte;
  assign o_re         = 1'b0;
  assign o_tx         = 1'b1;
  assign unused_rdata = ^i_rdata;
`endif

  assign o_addr  = addr_q;
  assign o_we    = we_q;
  assign o_wdata = wdata_q;
  assign o_busy  = busy_q;
  assign o_done  = done_q;
  assign o_err   = err_q;

  // Load sequencer: frame parsing, write strobes, echo readback/transmit and sticky status
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      we_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_ECHO_EN
      pend_q      <= 1'b0;
      pend_byte_q <= '0;
      last_q      <= 1'b0;
      re_q        <= 1'b0;
      wait_q      <= '0;
      echo_byte_q <= '0;
      tx_q        <= 1'b1;
      tx_busy_q   <= 1'b0;
      tx_sent_q   <= 1'b0;
      tx_sh_q     <= '1;
      tx_bits_q   <= '0;
      tx_baud_q   <= '0;
`endif
    end else begin
      we_q <= 1'b0;
      if (rx_ferr) err_q <= 1'b1;
`ifdef LOADER_ECHO_EN
      re_q <= 1'b0;
      // Echo shifter: start bit already on the line at load, then 8 data bits and the stop bit
      if (tx_busy_q) begin
        if (tx_baud_q == BAUD_M1) begin
          tx_baud_q <= '0;
          if (tx_bits_q == 4'd0) begin
            tx_busy_q <= 1'b0;
          end else begin
            tx_q      <= tx_sh_q[0];
            tx_sh_q   <= {1'b1, tx_sh_q[DATA_W:1]};
            tx_bits_q <= tx_bits_q - 4'd1;
          end
        end else begin
          tx_baud_q <= tx_baud_q + 1'b1;
        end
      end
      if (rx_valid && (state_q == ST_ECHO_RD || state_q == ST_ECHO_TX)) begin
        pend_q      <= 1'b1;
        pend_byte_q <= rx_byte;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          if (rx_valid) begin
            len_q[7:0] <= rx_byte;
            busy_q     <= 1'b1;
            state_q    <= ST_LEN_HI;
          end
        end
        ST_LEN_HI: begin
          if (rx_valid) begin
            len_q[8] <= rx_byte[0];
            state_q  <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (byte_avail) begin
            addr_q  <= count_q;
            wdata_q <= byte_in;
            we_q    <= 1'b1;
            count_q <= count_q + ADDR_W'(1);
`ifdef LOADER_ECHO_EN
            pend_q <= pend_q & rx_valid;
            if (pend_q && rx_valid) pend_byte_q <= rx_byte;
            last_q  <= is_last;
            wait_q  <= '0;
            state_q <= ST_ECHO_RD;
`else
            if (is_last) state_q <= ST_DONE;
`endif
          end
        end
`ifdef LOADER_ECHO_EN
        ST_ECHO_RD: begin
          // Read strobe two cycles after the write; read data arrives one cycle after the strobe
          wait_q <= wait_q + 2'd1;
          if (wait_q == 2'd1) re_q <= 1'b1;
          if (wait_q == 2'd3) begin
            echo_byte_q <= i_rdata;
            state_q     <= ST_ECHO_TX;
          end
        end
        ST_ECHO_TX: begin
          if (!tx_busy_q) begin
            if (tx_sent_q) begin
              state_q <= ST_DONE;
            end else begin
              tx_q      <= 1'b0;
              tx_sh_q   <= {1'b1, echo_byte_q};
              tx_bits_q <= 4'(FRAME_BITS - 1);
              tx_baud_q <= '0;
              tx_busy_q <= 1'b1;
              if (last_q) tx_sent_q <= 1'b1;
              else state_q <= ST_DATA;
            end
          end
        end
`endif
        ST_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// tb/tb_uart_mem_loader.sv - directed table-driven bench for uart_mem_loader
module tb_uart_mem_loader;

  localparam int DIV = 8;

  logic       clk = 1'b0;
  logic       nrst = 1'b0;
  logic       rx = 1'b1;
  logic [8:0] addr;
  logic       we, re, tx, busy, done, err;
  logic [7:0] wdata;
  logic [7:0] rdata = 8'h00;

  always #5 clk = ~clk;

  uart_mem_loader #(.pBAUD_DIV(DIV)) dut (
    .i_clk  (clk),
    .i_nrst (nrst),
    .i_rx   (rx),
    .o_addr (addr),
    .o_we   (we),
    .o_wdata(wdata),
    .o_re   (re),
    .i_rdata(rdata),
    .o_tx   (tx),
    .o_busy (busy),
    .o_done (done),
    .o_err  (err)
  );

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] mem [0:511];
  always @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata <= re ? mem[addr] : 8'h00;
  end

  typedef struct {
    logic [8:0] a;
    logic [7:0] d;
    int         c;
  } acc_t;

  acc_t       wr_log[$];
  acc_t       rd_log[$];
  logic       we_prev = 1'b0;
  logic       done_prev = 1'b0;
  logic [8:0] a_prev = '0;
  logic [7:0] d_prev = '0;
  int         we_long = 0;
  int         stab_bad = 0;
  int         both = 0;
  int         done_cyc = -1;

  always @(negedge clk) begin
    if (we) wr_log.push_back('{a: addr, d: wdata, c: cyc});
    if (re) rd_log.push_back('{a: addr, d: rdata, c: cyc});
    if (we && we_prev) we_long++;
    if (we_prev && (addr != a_prev || wdata != d_prev)) stab_bad++;
    if (we && re) both++;
    if (done && !done_prev) done_cyc = cyc;
    we_prev   = we;
    a_prev    = addr;
    d_prev    = wdata;
    done_prev = done;
  end

`ifdef LOADER_ECHO_EN
  logic [7:0] tx_log[$];
  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge tx);
      repeat (DIV / 2) @(posedge clk);
      for (int i = 0; i < 8; i++) begin
        repeat (DIV) @(posedge clk);
        b[i] = tx;
      end
      repeat (DIV) @(posedge clk);
      if (tx) tx_log.push_back(b);
    end
  end
`endif

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_ok);
    rx = 1'b0;
    repeat (DIV) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      repeat (DIV) @(negedge clk);
    end
    rx = stop_ok;
    repeat (DIV) @(negedge clk);
    rx = 1'b1;
    repeat (DIV) @(negedge clk);
  endtask

  task automatic do_reset();
    nrst = 1'b0;
    rx   = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_addr", addr, 0);
    chk("rst_we", we, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_re", re, 0);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_err", err, 0);
    wr_log.delete();
    rd_log.delete();
    done_cyc = -1;
    nrst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_done(input int maxc);
    int n = 0;
    while (!done && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk("done_wait", done, 1);
  endtask

  typedef struct {
    logic [7:0] b;
    logic       stop_ok;
    int         exp_wr;
    logic [8:0] ea;
    logic [7:0] ed;
    logic       eb;
    logic       edn;
    logic       ee;
  } vec_t;

  vec_t tbl[7];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n0, bad, last;

    tbl[0] = '{8'h03, 1'b1, 0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{8'h00, 1'b1, 0, 9'h000, 8'h00, 1'b1, 1'b0, 1'b0};
    tbl[2] = '{8'hA5, 1'b1, 1, 9'h000, 8'hA5, 1'b1, 1'b0, 1'b0};
    tbl[3] = '{8'h5A, 1'b1, 1, 9'h001, 8'h5A, 1'b1, 1'b0, 1'b0};
    tbl[4] = '{8'hFF, 1'b1, 1, 9'h002, 8'hFF, 1'b0, 1'b1, 1'b0};
    tbl[5] = '{8'h11, 1'b1, 0, 9'h000, 8'h00, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{8'h22, 1'b0, 0, 9'h000, 8'h00, 1'b0, 1'b1, 1'b1};

    do_reset();

    // Basic 3-byte frame, then bytes after completion
    for (int i = 0; i < 7; i++) begin
      n0 = wr_log.size();
      send_byte(tbl[i].b, tbl[i].stop_ok);
      if (tbl[i].edn) wait_done(400);
      chk($sformatf("t%0d_nwr", i), wr_log.size() - n0, tbl[i].exp_wr);
      if (tbl[i].exp_wr != 0) begin
        chk($sformatf("t%0d_addr", i), wr_log[wr_log.size()-1].a, tbl[i].ea);
        chk($sformatf("t%0d_data", i), wr_log[wr_log.size()-1].d, tbl[i].ed);
      end
      chk($sformatf("t%0d_busy", i), busy, tbl[i].eb);
      chk($sformatf("t%0d_done", i), done, tbl[i].edn);
      chk($sformatf("t%0d_err", i), err, tbl[i].ee);
    end
`ifndef LOADER_ECHO_EN
    chk("done_latency", done_cyc - wr_log[2].c, 1);
`endif

    // Short low glitch in idle must not start a byte
    do_reset();
    rx = 1'b0;
    repeat (DIV / 4) @(negedge clk);
    rx = 1'b1;
    repeat (12 * DIV) @(negedge clk);
    chk("glitch_busy", busy, 0);
    chk("glitch_nwr", wr_log.size(), 0);
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'h77, 1'b0);
    chk("ferr_err", err, 1);
    chk("ferr_nwr", wr_log.size(), 1);
    send_byte(8'hBB, 1'b1);
    wait_done(400);
    chk("ferr_nwr2", wr_log.size(), 2);
    chk("ferr_addr1", wr_log[1].a, 9'h001);
    chk("ferr_data1", wr_log[1].d, 8'hBB);

    // Reset in the middle of a load, then a fresh frame from address 0
    do_reset();
    send_byte(8'h05, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h11, 1'b1);
    send_byte(8'h22, 1'b1);
    chk("mid_nwr", wr_log.size(), 2);
    chk("mid_busy", busy, 1);
    do_reset();
    send_byte(8'h01, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h33, 1'b1);
    wait_done(400);
    chk("fresh_nwr", wr_log.size(), 1);
    chk("fresh_addr", wr_log[0].a, 9'h000);
    chk("fresh_data", wr_log[0].d, 8'h33);

    // Length 0 means a full 512-byte load
    do_reset();
    send_byte(8'h00, 1'b1);
    send_byte(8'h00, 1'b1);
    for (int i = 0; i < 512; i++) send_byte(8'(i), 1'b1);
    wait_done(400);
    chk("full_nwr", wr_log.size(), 512);
    bad = 0;
    for (int i = 0; i < wr_log.size(); i++)
      if (wr_log[i].a != 9'(i) || wr_log[i].d != 8'(i)) bad++;
    chk("full_seq_bad", bad, 0);
    last = wr_log.size() - 1;
    chk("full_last_addr", wr_log[last].a, 9'h1FF);
    chk("full_last_data", wr_log[last].d, 8'hFF);
    chk("full_busy", busy, 0);
    send_byte(8'h11, 1'b1);
    repeat (4 * DIV) @(negedge clk);
    chk("full_extra_nwr", wr_log.size(), 512);

`ifdef LOADER_ECHO_EN
    // Echo readback and retransmission
    do_reset();
    tx_log.delete();
    send_byte(8'h02, 1'b1);
    send_byte(8'h00, 1'b1);
    send_byte(8'h3C, 1'b1);
    send_byte(8'hC3, 1'b1);
    wait_done(40 * DIV);
    repeat (2 * DIV) @(negedge clk);
    chk("echo_nrd", rd_log.size(), 2);
    chk("echo_ntx", tx_log.size(), 2);
    if (rd_log.size() == 2 && wr_log.size() == 2) begin
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("echo_re_lat%0d", k), rd_log[k].c - wr_log[k].c, 2);
        chk($sformatf("echo_re_addr%0d", k), rd_log[k].a, wr_log[k].a);
      end
      chk("echo_done_after_tx", done_cyc > rd_log[1].c + 10 * DIV, 1);
    end
    if (tx_log.size() == 2) begin
      chk("echo_tx0", tx_log[0], 8'h3C);
      chk("echo_tx1", tx_log[1], 8'hC3);
    end
`endif

    chk("we_single_cycle", we_long, 0);
    chk("wr_stable_after", stab_bad, 0);
    chk("we_re_exclusive", both, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
